srt_fp32_quotient_finalizer: RTL

Downstream completion stage for the FP32 SRT divider. It consumes the radix-2 signed quotient digit stream and the final partial-remainder status, and performs on-the-fly conversion to binary, negative-remainder correction, normalization, round-to-nearest-even and exponent range checks. It emits the packed IEEE-754 single-precision quotient with a one-cycle `done` pulse.

---
 rtl/srt_fp32_quotient_finalizer.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/srt_fp32_quotient_finalizer.sv
// Completion stage for the FP32 SRT divider: on-the-fly digit conversion, remainder correction,
// normalization, rounding and exponent range checks. Define SRT_FINALIZER_RNE_EN for round-to-nearest-even.
module srt_fp32_quotient_finalizer #(
    parameter int NDIGITS = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sign_in,
    input  logic [9:0]  exp_in,
    input  logic [1:0]  special_in,
    input  logic        digit_valid,
    input  logic [1:0]  digit,
    input  logic        rem_valid,
    input  logic        rem_neg,
    input  logic        rem_nz,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic        ovf,
    output logic        unf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_WAIT_REM,
        S_ROUND,
        S_SPEC
    } state_t;

    localparam logic [4:0] LAST_DIGIT = 5'(NDIGITS - 1);

    state_t               state_q, state_d;
    logic [NDIGITS-1:0]   q_q, q_d;
    logic [NDIGITS-1:0]   qm_q, qm_d;
    logic [NDIGITS-1:0]   r_q, r_d;
    logic [4:0]           cnt_q, cnt_d;
    logic                 nz_q, nz_d;
    logic                 sign_q, sign_d;
    logic [9:0]           exp_q, exp_d;
    logic [1:0]           spec_q, spec_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [31:0]          quot_q, quot_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;

    // Rounding datapath, evaluated from the latched corrected quotient R.
    logic [22:0]          mant_raw;
    logic [23:0]          mant_sum;
    logic                 round_up;
    logic signed [10:0]   e_base;
    logic signed [10:0]   e_adj;
    logic signed [10:0]   e_fin;
    logic [31:0]          res_quot;
    logic                 res_ovf;
    logic                 res_unf;

`ifdef SRT_FINALIZER_RNE_EN
    logic                 guard;
    logic                 sticky;
`else
    logic                 unused_round;
    assign unused_round = ^{r_q[1:0], nz_q};
`endif

    always_comb begin
        e_base   = {exp_q[9], exp_q};
        mant_raw = '0;
        e_adj    = e_base;
`ifdef SRT_FINALIZER_RNE_EN
        guard    = 1'b0;
        sticky   = 1'b0;
`endif
        if (r_q[26]) begin
            mant_raw = r_q[25:3];
            e_adj    = e_base;
`ifdef SRT_FINALIZER_RNE_EN
            guard    = r_q[2];
            sticky   = (|r_q[1:0]) | nz_q;
`endif
        end else begin
            mant_raw = r_q[24:2];
            e_adj    = e_base - 11'sd1;
`ifdef SRT_FINALIZER_RNE_EN
            guard    = r_q[1];
            sticky   = r_q[0] | nz_q;
`endif
        end
`ifdef SRT_FINALIZER_RNE_EN
        round_up = guard & (sticky | mant_raw[0]);
`else
        round_up = 1'b0;
`endif
        // A carry out leaves the low 23 bits all zero, which is exactly the renormalized mantissa.
        mant_sum = {1'b0, mant_raw} + {23'd0, round_up};
        e_fin    = mant_sum[23] ? (e_adj + 11'sd1) : e_adj;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (e_fin >= 11'sd255) begin
            res_quot = {sign_q, 8'hFF, 23'd0};
            res_ovf  = 1'b1;
        end else if (e_fin <= 11'sd0) begin
            res_quot = {sign_q, 31'd0};
            res_unf  = 1'b1;
        end else begin
            res_quot = {sign_q, e_fin[7:0], mant_sum[22:0]};
        end
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        qm_d    = qm_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        nz_d    = nz_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        spec_d  = spec_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sign_d = sign_in;
                    exp_d  = exp_in;
                    spec_d = special_in;
                    busy_d = 1'b1;
                    if (special_in == 2'b00) begin
                        q_d     = '0;
                        qm_d    = '0;
                        cnt_d   = '0;
                        state_d = S_CONV;
                    end else begin
                        state_d = S_SPEC;
                    end
                end
            end
            S_CONV: begin
                if (digit_valid) begin
                    // QM tracks Q minus one ulp so a -1 digit never needs a borrow chain.
                    case (digit)
                        2'b01: begin
                            q_d  = {q_q[NDIGITS-2:0], 1'b1};
                            qm_d = {q_q[NDIGITS-2:0], 1'b0};
                        end
                        2'b11: begin
                            q_d  = {qm_q[NDIGITS-2:0], 1'b1};
                            qm_d = {qm_q[NDIGITS-2:0], 1'b0};
                        end
                        default: begin
                            q_d  = {q_q[NDIGITS-2:0], 1'b0};
                            qm_d = {qm_q[NDIGITS-2:0], 1'b1};
                        end
                    endcase
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == LAST_DIGIT) begin
                        state_d = S_WAIT_REM;
                    end
                end
            end
            S_WAIT_REM: begin
                if (rem_valid) begin
                    r_d     = rem_neg ? qm_q : q_q;
                    nz_d    = rem_nz;
                    state_d = S_ROUND;
                end
            end
            S_ROUND: begin
                quot_d  = res_quot;
                ovf_d   = res_ovf;
                unf_d   = res_unf;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            S_SPEC: begin
                case (spec_q)
                    2'b01:   quot_d = {sign_q, 31'd0};
                    2'b10:   quot_d = {sign_q, 8'hFF, 23'd0};
                    default: quot_d = 32'h7FC0_0000;
                endcase
                ovf_d   = 1'b0;
                unf_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            q_q     <= '0;
            qm_q    <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            nz_q    <= 1'b0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            spec_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            qm_q    <= qm_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            nz_q    <= nz_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            spec_q  <= spec_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quot_q;
    assign ovf      = ovf_q;
    assign unf      = unf_q;

endmodule
